// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath, stalling on mem_ready.
module multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state_dbg,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore decode of the state; FETCH and BRANCH also look at mem_ready / zero.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // Reset silences every strobe immediately, even before the clock edge.
        if (reset) begin
            pc_en      = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_src     = 2'b00;
        end
    end

    assign state_dbg = reset ? 4'd0 : state_q;
    assign illegal   = illegal_q & ~reset;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-subset core.
- Sequences the shared datapath (memory port, IR, register file, ALU, PC) through fetch, decode, execute, memory and writeback steps.
- Drives the 2-bit alu_op consumed by the ALU control decoder: 00 = add, 01 = sub, 10 = R-type funct decode.
- Stalls on a single-port memory ready handshake.

Parameters:
HALT_ON_ILLEGAL, 1, 1: an illegal opcode parks the FSM in HALT until reset; 0: the instruction is skipped and the FSM returns to FETCH.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  instruction register bits [31:26]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_en  out  1  PC register load enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_dst  out  1  write-register select: 0 = rt, 1 = rd
mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
alu_op  out  2  to ALU control
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state_dbg  out  4  current state encoding
illegal  out  1  sticky flag: an illegal opcode was decoded

Behaviour:
- Reset:
  - When reset is high at a clk edge: state <= FETCH and illegal <= 0.
  - While reset is high, every control output is forced to 0, including alu_op = 00 and pc_src = 00.
  - Reset mid-instruction aborts the instruction; no further write strobes are issued.
- Outputs:
  - All outputs are Moore decodes of the state.
  - Exception: pc_en in BRANCH equals zero.
  - Any output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=15.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_en equal mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode: illegal <= 1, then HALT if HALT_ON_ILLEGAL=1, else FETCH.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: MEMRD if opcode=100011, else MEMWR.
- MEMRD:
  - Outputs: mem_read=1, iord=1.
  - Holds until mem_ready=1, then MEMWB.
- MEMWB:
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: mem_write=1, iord=1.
  - Holds until mem_ready=1, then FETCH.
  - mem_write stays high for the entire hold.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
- JUMP: pc_src=10, pc_en=1; next state FETCH.
- HALT: all outputs 0; leaves only on reset.
- Undefined state codes go to FETCH on the next edge.
- Cycle counts with mem_ready tied to 1:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Invariant: mem_read and mem_write are never both 1 in the same cycle.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 and opcode=000000 -> state_dbg sequence 0,1,6,7,0. reg_write=1 only in state 7, with reg_dst=1. alu_op=10 in state 6.
- lw (100011), mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. iord=1 throughout MEMRD. mem_to_reg=1 and reg_write=1 in state 4.
- beq (000100), once with zero=1 and once with zero=0 -> 3 cycles each. pc_en=1 in BRANCH only when zero=1. alu_op=01, pc_src=01.
- sw (101011) with mem_ready low 2 cycles -> mem_write=1 for exactly 3 cycles, mem_read=0 throughout, reg_write never asserted.
- Opcode 111111: with HALT_ON_ILLEGAL=1 -> state 15 and illegal=1; both persist for 10 cycles and clear after reset. With HALT_ON_ILLEGAL=0 -> back to FETCH with illegal=1.
- Reset asserted during MEMWR with mem_ready=0 -> the next cycle shows state 0, mem_write=0 and all outputs 0 while reset is high.
